// File: rtl/npc_pkg.sv
// npc_pkg: shared state encodings, redirect selects and default vectors for npc_gen
package npc_pkg;
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } npc_state_e;
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic SEL_PCIMM = 1'b0;
    localparam logic SEL_RAIMM = 1'b1;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
endpackage

// File: rtl/npc_target.sv
// npc_target: combinational redirect target, misalignment check and link address
module npc_target
    import npc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INC        = 4,
    parameter int ALIGN_BITS = 2
) (
    input  logic            redir_sel_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ra_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] tgt_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] link_o
);
    logic [XLEN-1:0] w_sum;
    assign w_sum      = ((redir_sel_i == SEL_RAIMM) ? ra_i : ex_pc_i) + imm_i;
    assign tgt_o      = (redir_sel_i == SEL_RAIMM) ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign misalign_o = |tgt_o[ALIGN_BITS-1:0];
    assign link_o     = ex_pc_i + XLEN'(INC);
endmodule

// File: rtl/npc_gen.sv
// npc_gen: fetch PC register with BOOT/RUN/HALT control, EX redirects, trap vector and redirect counter
module npc_gen
    import npc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
    parameter int              INC        = 4,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
    parameter int              ALIGN_BITS = 2,
    parameter int              CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_ready_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             redir_valid_i,
    input  logic             redir_sel_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ra_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             valid_o,
    output logic [XLEN-1:0]  link_o,
    output logic             flush_o,
    output logic             trap_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] redir_cnt_o
);
    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_flush;
    logic             r_trap;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  w_tgt;
    logic             w_misalign;

    npc_target #(.XLEN(XLEN), .INC(INC), .ALIGN_BITS(ALIGN_BITS)) u_target (
        .redir_sel_i (redir_sel_i),
        .ex_pc_i     (ex_pc_i),
        .ra_i        (ra_i),
        .imm_i       (imm_i),
        .tgt_o       (w_tgt),
        .misalign_o  (w_misalign),
        .link_o      (link_o)
    );

    // Redirects outrank the sequential advance; BOOT ignores both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_trap  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_flush <= 1'b0;
            r_trap  <= 1'b0;
            if (r_state == ST_BOOT) begin
                r_state <= ST_RUN;
            end else begin
                if (redir_valid_i) begin
                    r_pc    <= w_misalign ? TRAP_VEC : w_tgt;
                    r_flush <= 1'b1;
                    r_trap  <= w_misalign;
                    r_cnt   <= r_cnt + 1'b1;
                end else if (r_state == ST_RUN && fetch_ready_i) begin
                    r_pc <= r_pc + XLEN'(INC);
                end
                if (r_state == ST_RUN && halt_i)
                    r_state <= ST_HALT;
                else if (r_state == ST_HALT && resume_i && !halt_i)
                    r_state <= ST_RUN;
            end
        end
    end

    assign pc_o        = r_pc;
    assign valid_o     = (r_state == ST_RUN);
    assign flush_o     = r_flush;
    assign trap_o      = r_trap;
    assign state_o     = r_state;
    assign redir_cnt_o = r_cnt;
endmodule

// File: tb/tb_npc_gen.sv
// tb_npc_gen: directed checks of npc_gen sequencing, redirects, traps, halt/resume and wraps
module tb_npc_gen;
    logic        clk, rst, ready, halt, resume, redir, sel;
    logic [31:0] ex_pc, ra, imm;
    logic [31:0] pc, link;
    logic        valid, flush, trap;
    logic [1:0]  state;
    logic [15:0] cnt;
    logic [31:0] pc_s, link_s;
    logic        valid_s, flush_s, trap_s;
    logic [1:0]  state_s;
    logic [2:0]  cnt_s;
    int          n_checks = 0;
    int          n_fail = 0;

    npc_gen dut (
        .clk_i(clk), .rst_i(rst), .fetch_ready_i(ready), .halt_i(halt), .resume_i(resume),
        .redir_valid_i(redir), .redir_sel_i(sel), .ex_pc_i(ex_pc), .ra_i(ra), .imm_i(imm),
        .pc_o(pc), .valid_o(valid), .link_o(link), .flush_o(flush), .trap_o(trap),
        .state_o(state), .redir_cnt_o(cnt)
    );

    npc_gen #(.CNT_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .fetch_ready_i(ready), .halt_i(halt), .resume_i(resume),
        .redir_valid_i(redir), .redir_sel_i(sel), .ex_pc_i(ex_pc), .ra_i(ra), .imm_i(imm),
        .pc_o(pc_s), .valid_o(valid_s), .link_o(link_s), .flush_o(flush_s), .trap_o(trap_s),
        .state_o(state_s), .redir_cnt_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; ready = 1; halt = 0; resume = 0; redir = 0; sel = 0;
        ex_pc = 0; ra = 0; imm = 0;
        step(); step();
        n_checks++;
        if ({pc, valid, state, flush, trap, cnt} !== {32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset: pc=%h valid=%b state=%0d flush=%b trap=%b cnt=%h", pc, valid, state, flush, trap, cnt);
        end
        rst = 0;
        n_checks++;
        if ({pc, valid} !== {32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL boot_cycle1: pc=%h valid=%b want 0/0", pc, valid);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({pc, valid, state} !== {32'(4 * i), 1'b1, 2'd1}) begin
                n_fail++;
                $display("FAIL seq_%0d: pc=%h valid=%b state=%0d want pc=%h", i, pc, valid, state, 32'(4 * i));
            end
        end
    endtask

    task automatic test_hold();
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({pc, valid} !== {32'h10, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_%0d: pc=%h valid=%b want 10/1", i, pc, valid);
            end
        end
    endtask

    task automatic test_redirect();
        redir = 1; sel = 0; ex_pc = 32'h20; imm = 32'hFFFF_FFF0; ready = 1;
        #1;
        n_checks++;
        if (link !== 32'h24) begin
            n_fail++;
            $display("FAIL link_br: got %h want 24", link);
        end
        step();
        redir = 0; ready = 0;
        n_checks++;
        if ({pc, flush, trap, cnt} !== {32'h10, 1'b1, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL redir_br: pc=%h flush=%b trap=%b cnt=%0d want 10/1/0/1", pc, flush, trap, cnt);
        end
        step();
        n_checks++;
        if ({pc, flush} !== {32'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_pulse: pc=%h flush=%b want 10/0", pc, flush);
        end
    endtask

    task automatic test_trap();
        redir = 1; sel = 1; ra = 32'h103; imm = 0;
        step();
        redir = 0;
        n_checks++;
        if ({pc, trap, flush, cnt} !== {32'h100, 1'b1, 1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL trap_jalr: pc=%h trap=%b flush=%b cnt=%0d want 100/1/1/2", pc, trap, flush, cnt);
        end
        step();
        n_checks++;
        if ({trap, flush} !== 2'b00) begin
            n_fail++;
            $display("FAIL trap_pulse: trap=%b flush=%b want 0/0", trap, flush);
        end
        redir = 1; sel = 1; ra = 32'h200; imm = 4; ex_pc = 32'h300;
        #1;
        n_checks++;
        if (link !== 32'h304) begin
            n_fail++;
            $display("FAIL link_jalr: got %h want 304", link);
        end
        step();
        n_checks++;
        if ({pc, trap, flush, cnt} !== {32'h204, 1'b0, 1'b1, 16'd3}) begin
            n_fail++;
            $display("FAIL jalr_ok: pc=%h trap=%b flush=%b cnt=%0d want 204/0/1/3", pc, trap, flush, cnt);
        end
        ra = 32'h201; imm = 3;
        step();
        n_checks++;
        if ({pc, trap} !== {32'h204, 1'b0}) begin
            n_fail++;
            $display("FAIL jalr_bit0: pc=%h trap=%b want 204/0", pc, trap);
        end
        sel = 0; ex_pc = 32'h10; imm = 2;
        step();
        redir = 0;
        n_checks++;
        if ({pc, trap, cnt} !== {32'h100, 1'b1, 16'd5}) begin
            n_fail++;
            $display("FAIL br_misalign: pc=%h trap=%b cnt=%0d want 100/1/5", pc, trap, cnt);
        end
    endtask

    task automatic test_halt();
        redir = 1; sel = 0; ex_pc = 32'h40; imm = 0; ready = 0;
        step();
        redir = 0; halt = 1; ready = 1;
        step();
        halt = 0;
        n_checks++;
        if ({pc, valid, state} !== {32'h44, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL halt_enter: pc=%h valid=%b state=%0d want 44/0/2", pc, valid, state);
        end
        step();
        n_checks++;
        if ({pc, valid} !== {32'h44, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_hold: pc=%h valid=%b want 44/0", pc, valid);
        end
        redir = 1; ex_pc = 32'h80;
        step();
        redir = 0;
        n_checks++;
        if ({pc, flush, state, cnt} !== {32'h80, 1'b1, 2'd2, 16'd7}) begin
            n_fail++;
            $display("FAIL halt_redir: pc=%h flush=%b state=%0d cnt=%0d want 80/1/2/7", pc, flush, state, cnt);
        end
        halt = 1; resume = 1;
        step();
        n_checks++;
        if ({state, valid} !== {2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_resume_both: state=%0d valid=%b want 2/0", state, valid);
        end
        halt = 0; ready = 0;
        step();
        resume = 0;
        n_checks++;
        if ({pc, valid, state} !== {32'h80, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL resume: pc=%h valid=%b state=%0d want 80/1/1", pc, valid, state);
        end
    endtask

    task automatic test_pc_wrap();
        redir = 1; sel = 0; ex_pc = 0; imm = 32'hFFFF_FFFC;
        step();
        redir = 0; ready = 1;
        n_checks++;
        if (pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_load: pc=%h want fffffffc", pc);
        end
        step();
        ready = 0;
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h want 0", pc);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1;
        step();
        rst = 0; redir = 1; sel = 0; ex_pc = 32'h1000; imm = 0;
        step();
        n_checks++;
        if ({pc, flush, cnt, state} !== {32'h0, 1'b0, 16'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL boot_redir_ignored: pc=%h flush=%b cnt=%0d state=%0d want 0/0/0/1", pc, flush, cnt, state);
        end
        for (int i = 1; i <= 8; i++) begin
            imm = 32'(8 * i);
            step();
            n_checks++;
            if ({pc, flush, cnt, cnt_s} !== {32'h1000 + 32'(8 * i), 1'b1, 16'(i), 3'(i)}) begin
                n_fail++;
                $display("FAIL b2b_%0d: pc=%h flush=%b cnt=%0d cnt_s=%0d want cnt=%0d cnt_s=%0d", i, pc, flush, cnt, cnt_s, i, i % 8);
            end
        end
        redir = 0;
    endtask

    task automatic test_reset_in_halt();
        halt = 1;
        step();
        halt = 0; redir = 1; ex_pc = 32'h500; imm = 0; rst = 1;
        step();
        redir = 0; rst = 0;
        n_checks++;
        if ({pc, state, valid, flush, cnt} !== {32'h0, 2'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_halt: pc=%h state=%0d valid=%b flush=%b cnt=%0d want 0/0/0/0/0", pc, state, valid, flush, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_redirect();
        test_trap();
        test_halt();
        test_pc_wrap();
        test_back_to_back();
        test_reset_in_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
